// File: rtl/icc_forward_unit_if.sv
// ---------------------------------------------------------------------------
// icc_forward_unit_if
//   Bundles the EX-side condition-code inputs, pipeline control, explicit
//   icc write port and the forwarded/committed flag outputs of
//   icc_forward_unit.
//   master : the pipeline side (drives EX/control/WRPSR, reads flags)
//   slave  : icc_forward_unit itself
//   Flag vectors are always {N,Z,V,C} = [3:0].
// ---------------------------------------------------------------------------
interface icc_forward_unit_if;
    logic       ex_valid;
    logic       ex_cc_we;
    logic [3:0] ex_flags;
    logic       stall;
    logic       flush;
    logic       psr_wr_en;
    logic [3:0] psr_wr_icc;
    logic       sticky_clr;
    logic       N_CC;
    logic       Z_CC;
    logic       V_CC;
    logic       C_CC;
    logic [3:0] icc_arch;
    logic       cc_pending;
    logic       ov_sticky;

    modport master (
        output ex_valid, ex_cc_we, ex_flags, stall, flush,
               psr_wr_en, psr_wr_icc, sticky_clr,
        input  N_CC, Z_CC, V_CC, C_CC, icc_arch, cc_pending, ov_sticky
    );

    modport slave (
        input  ex_valid, ex_cc_we, ex_flags, stall, flush,
               psr_wr_en, psr_wr_icc, sticky_clr,
        output N_CC, Z_CC, V_CC, C_CC, icc_arch, cc_pending, ov_sticky
    );
endinterface

// File: rtl/icc_forward_unit.sv
// ---------------------------------------------------------------------------
// icc_forward_unit
//   Producer side of the branch condition codes. Captures {N,Z,V,C} from
//   cc-setting ALU ops in EX, carries them through PIPE_DEPTH in-flight
//   stages (stage[0]=MEM .. stage[PIPE_DEPTH-1]=WB), commits them to the
//   architectural icc at WB, and forwards the newest valid flags to the
//   branch condition evaluator so no stall is needed after ADDcc/SUBcc.
//
// Parameters
//   PIPE_DEPTH  in-flight stages between EX and commit (1..3)
//   RESET_ICC   architectural {N,Z,V,C} after reset
//
// Ports
//   clk    rising-edge clock
//   reset  asynchronous, active-high
//   bus    icc_forward_unit_if.slave: EX capture inputs, stall/flush,
//          WRPSR write, sticky clear; forwarded N/Z/V/C_CC, icc_arch,
//          cc_pending, ov_sticky
//
// Build option
//   ICC_STICKY_OV_EN  adds a sticky overflow bit set by any commit with V=1
//                     and cleared by sticky_clr; without it ov_sticky is 0.
// ---------------------------------------------------------------------------
module icc_forward_unit #(
    parameter int         PIPE_DEPTH = 2,
    parameter logic [3:0] RESET_ICC  = 4'b0000
) (
    input  logic                  clk,
    input  logic                  reset,
    icc_forward_unit_if.slave     bus
);

    localparam int LAST = PIPE_DEPTH - 1;

    logic                       w_cap;
    logic [PIPE_DEPTH-1:0]      r_stage_vld;
    logic [PIPE_DEPTH-1:0][3:0] r_stage_flags;
    logic [3:0]                 r_icc_arch;
    logic [3:0]                 w_fwd;

    // Capture ignores stall: the EX op is still visible for forwarding while
    // the pipe is frozen; stall only governs whether it moves on.
    assign w_cap = bus.ex_valid & bus.ex_cc_we & ~bus.flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stage_vld   <= '0;
            r_stage_flags <= '0;
            r_icc_arch    <= RESET_ICC;
        end else if (!bus.stall) begin
            r_stage_vld[0]   <= w_cap;
            r_stage_flags[0] <= bus.ex_flags;
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                r_stage_vld[i]   <= r_stage_vld[i-1];
                r_stage_flags[i] <= r_stage_flags[i-1];
            end
            // WRPSR overrides a same-cycle WB commit; that commit is lost.
            if (bus.psr_wr_en) begin
                r_icc_arch <= bus.psr_wr_icc;
            end else if (r_stage_vld[LAST]) begin
                r_icc_arch <= r_stage_flags[LAST];
            end
        end
    end

    // Oldest first so each younger valid stage overrides, EX wins last.
    always_comb begin
        w_fwd = r_icc_arch;
        for (int i = LAST; i >= 0; i--) begin
            if (r_stage_vld[i]) begin
                w_fwd = r_stage_flags[i];
            end
        end
        if (w_cap) begin
            w_fwd = bus.ex_flags;
        end
    end

    assign bus.N_CC       = w_fwd[3];
    assign bus.Z_CC       = w_fwd[2];
    assign bus.V_CC       = w_fwd[1];
    assign bus.C_CC       = w_fwd[0];
    assign bus.icc_arch   = r_icc_arch;
    assign bus.cc_pending = w_cap | (|r_stage_vld);

`ifdef ICC_STICKY_OV_EN
    logic r_ov_sticky;
    logic w_commit_v;

    // V of whatever actually lands in icc_arch this edge.
    assign w_commit_v = bus.psr_wr_en ? bus.psr_wr_icc[1]
                                      : (r_stage_vld[LAST] & r_stage_flags[LAST][1]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ov_sticky <= 1'b0;
        end else if (!bus.stall) begin
            if (w_commit_v) begin
                r_ov_sticky <= 1'b1;
            end else if (bus.sticky_clr) begin
                r_ov_sticky <= 1'b0;
            end
        end
    end

    assign bus.ov_sticky = r_ov_sticky;
`else
    assign bus.ov_sticky = 1'b0;
`endif

endmodule
